// File: rtl/argmax_tree_pkg.sv
// Shared sizing helpers for the argmax tree: log2, tree depth and per-level node counts.
// Pure elaboration-time functions, no logic.
// No flow control here.
package argmax_tree_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int p = 1; p < n; p = p * 2) begin
            r++;
        end
        return r;
    endfunction

    // A single input still passes through one register, so the depth floor is 1.
    function automatic int tree_latency(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int level_width(input int n, input int lvl);
        int w;
        w = n;
        for (int i = 0; i < lvl; i++) begin
            w = (w + 1) / 2;
        end
        return w;
    endfunction

endpackage

// File: rtl/argmax_node.sv
// One registered compare stage: keeps the larger of a/b (a wins ties), or forwards a when bypassed.
// Latency 1 cycle.
// No backpressure; data registers hold while valid is low.
module argmax_node
    import argmax_tree_pkg::*;
#(
    parameter int RESOLUTION = 8,
    parameter int INDEX_SIZE = 4,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_vld,
    input  logic                  bypass,
    input  logic [RESOLUTION-1:0] a_val,
    input  logic [INDEX_SIZE-1:0] a_idx,
    input  logic [RESOLUTION-1:0] b_val,
    input  logic [INDEX_SIZE-1:0] b_idx,
    output logic                  out_vld,
    output logic [RESOLUTION-1:0] out_val,
    output logic [INDEX_SIZE-1:0] out_idx
);

    logic                  a_ge_b;
    logic                  a_wins;
    logic                  vld_d, vld_q;
    logic [RESOLUTION-1:0] val_d, val_q;
    logic [INDEX_SIZE-1:0] idx_d, idx_q;

    always_comb begin
        if (SIGNED != 0) begin
            a_ge_b = $signed(a_val) >= $signed(b_val);
        end else begin
            a_ge_b = a_val >= b_val;
        end
        a_wins = bypass | a_ge_b;

        vld_d = in_vld;
        val_d = val_q;
        idx_d = idx_q;
        if (in_vld) begin
            val_d = a_wins ? a_val : b_val;
            idx_d = a_wins ? a_idx : b_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            val_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            val_q <= val_d;
            idx_q <= idx_d;
        end
    end

    assign out_vld = vld_q;
    assign out_val = val_q;
    assign out_idx = idx_q;

endmodule

// File: rtl/argmax_tree.sv
// Pipelined argmax over NUM_INPUTS scores: balanced tree of registered compare nodes.
// Latency max(1, clog2(NUM_INPUTS)) cycles, one vector per cycle.
// No backpressure; outputs hold the last result while out_valid is low.
module argmax_tree
    import argmax_tree_pkg::*;
#(
    parameter int RESOLUTION = 8,
    parameter int NUM_INPUTS = 10,
    parameter int SIGNED     = 0,
    parameter int INDEX_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [NUM_INPUTS*RESOLUTION-1:0] in_data,
    output logic                             out_valid,
    output logic [RESOLUTION-1:0]            out_val,
    output logic [INDEX_SIZE-1:0]            out_idx
);

    localparam int LAT = tree_latency(NUM_INPUTS);
    localparam int VW  = NUM_INPUTS * RESOLUTION;
    localparam int IW  = NUM_INPUTS * INDEX_SIZE;

    // Every level is sized for the full input count; slots past a level's width are tied to zero.
    logic [VW-1:0]         lvl_val [0:LAT];
    logic [IW-1:0]         lvl_idx [0:LAT];
    logic [NUM_INPUTS-1:0] lvl_vld [0:LAT];

    assign lvl_val[0] = in_data;
    assign lvl_vld[0] = {NUM_INPUTS{in_valid}};

    for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_idx0
        assign lvl_idx[0][j*INDEX_SIZE +: INDEX_SIZE] = INDEX_SIZE'(j);
    end

    for (genvar l = 1; l <= LAT; l++) begin : g_lvl
        localparam int W  = level_width(NUM_INPUTS, l);
        localparam int WP = level_width(NUM_INPUTS, l - 1);

        for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_slot
            if (j < W) begin : g_node
                // The odd element at the end of a level has no partner and is forwarded.
                localparam bit BYP = (2 * j + 1 >= WP);
                localparam int R   = BYP ? 2 * j : 2 * j + 1;

                argmax_node #(
                    .RESOLUTION (RESOLUTION),
                    .INDEX_SIZE (INDEX_SIZE),
                    .SIGNED     (SIGNED)
                ) u_node (
                    .clk     (clk),
                    .reset   (reset),
                    .in_vld  (lvl_vld[l-1][2*j]),
                    .bypass  (BYP),
                    .a_val   (lvl_val[l-1][2*j*RESOLUTION +: RESOLUTION]),
                    .a_idx   (lvl_idx[l-1][2*j*INDEX_SIZE +: INDEX_SIZE]),
                    .b_val   (lvl_val[l-1][R*RESOLUTION +: RESOLUTION]),
                    .b_idx   (lvl_idx[l-1][R*INDEX_SIZE +: INDEX_SIZE]),
                    .out_vld (lvl_vld[l][j]),
                    .out_val (lvl_val[l][j*RESOLUTION +: RESOLUTION]),
                    .out_idx (lvl_idx[l][j*INDEX_SIZE +: INDEX_SIZE])
                );
            end else begin : g_pad
                assign lvl_vld[l][j]                            = 1'b0;
                assign lvl_val[l][j*RESOLUTION +: RESOLUTION]   = '0;
                assign lvl_idx[l][j*INDEX_SIZE +: INDEX_SIZE]   = '0;
            end
        end
    end

    assign out_valid = lvl_vld[LAT][0];
    assign out_val   = lvl_val[LAT][RESOLUTION-1:0];
    assign out_idx   = lvl_idx[LAT][INDEX_SIZE-1:0];

endmodule

// File: tb/tb_argmax_tree.sv
// Scoreboard bench for argmax_tree: four configurations (10 unsigned, 10 signed, 5, 1) share one stimulus stream.
module tb_argmax_tree;

    typedef struct packed {
        logic [7:0]  val;
        logic [3:0]  idx;
        logic [31:0] cyc;
    } exp_t;

    localparam int NS [4] = '{10, 10, 5, 1};
    localparam int SG [4] = '{0, 1, 0, 0};
    localparam int LT [4] = '{4, 4, 3, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [79:0] in_a = '0;
    logic [39:0] in_c = '0;
    logic [7:0]  in_d = '0;

    logic       a_vld, b_vld, c_vld, d_vld;
    logic [7:0] a_val, b_val, c_val, d_val;
    logic [3:0] a_idx, b_idx;
    logic [2:0] c_idx;
    logic [0:0] d_idx;

    logic       o_vld [4];
    logic [7:0] o_val [4];
    logic [3:0] o_idx [4];

    logic [7:0] sc [10];
    exp_t       sb [4][$];
    logic [7:0] last_val [4];
    logic [3:0] last_idx [4];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    argmax_tree #(.RESOLUTION(8), .NUM_INPUTS(10), .SIGNED(0), .INDEX_SIZE(4)) u_dut_a (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_data(in_a),
        .out_valid(a_vld), .out_val(a_val), .out_idx(a_idx));
    argmax_tree #(.RESOLUTION(8), .NUM_INPUTS(10), .SIGNED(1), .INDEX_SIZE(4)) u_dut_b (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_data(in_a),
        .out_valid(b_vld), .out_val(b_val), .out_idx(b_idx));
    argmax_tree #(.RESOLUTION(8), .NUM_INPUTS(5), .SIGNED(0), .INDEX_SIZE(3)) u_dut_c (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_data(in_c),
        .out_valid(c_vld), .out_val(c_val), .out_idx(c_idx));
    argmax_tree #(.RESOLUTION(8), .NUM_INPUTS(1), .SIGNED(0), .INDEX_SIZE(1)) u_dut_d (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_data(in_d),
        .out_valid(d_vld), .out_val(d_val), .out_idx(d_idx));

    assign o_vld[0] = a_vld;  assign o_val[0] = a_val;  assign o_idx[0] = a_idx;
    assign o_vld[1] = b_vld;  assign o_val[1] = b_val;  assign o_idx[1] = b_idx;
    assign o_vld[2] = c_vld;  assign o_val[2] = c_val;  assign o_idx[2] = {1'b0, c_idx};
    assign o_vld[3] = d_vld;  assign o_val[3] = d_val;  assign o_idx[3] = {3'b000, d_idx};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Linear scan, strict greater-than so the lowest index keeps a tie.
    function automatic exp_t model(input int n, input int sgn);
        exp_t e;
        e.val = sc[0];
        e.idx = 4'd0;
        e.cyc = '0;
        for (int i = 1; i < n; i++) begin
            if ((sgn != 0) ? ($signed(sc[i]) > $signed(e.val)) : (sc[i] > e.val)) begin
                e.val = sc[i];
                e.idx = 4'(i);
            end
        end
        return e;
    endfunction

    task automatic send(input logic v, input logic r);
        exp_t e;
        @(posedge clk);
        #2;
        rst      = r;
        in_valid = v;
        for (int i = 0; i < 10; i++) in_a[i*8 +: 8] = sc[i];
        for (int i = 0; i < 5; i++)  in_c[i*8 +: 8] = sc[i];
        in_d = sc[0];
        if (v && !r) begin
            for (int d = 0; d < 4; d++) begin
                e     = model(NS[d], SG[d]);
                e.cyc = 32'(cyc + LT[d]);
                sb[d].push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 10; i++) sc[i] = 8'($urandom);
            send(1'b0, 1'b0);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 10; i++) sc[i] = v;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic ev;
        if (rst) begin
            for (int d = 0; d < 4; d++) begin
                sb[d].delete();
                last_val[d] = '0;
                last_idx[d] = '0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                while (sb[d].size() > 0 && sb[d][0].cyc < 32'(cyc)) void'(sb[d].pop_front());
                ev = (sb[d].size() > 0) && (sb[d][0].cyc == 32'(cyc));
                chk($sformatf("dut%0d out_valid", d), 32'(o_vld[d]), 32'(ev));
                if (ev) begin
                    e = sb[d].pop_front();
                    last_val[d] = e.val;
                    last_idx[d] = e.idx;
                end
                if (ev || !o_vld[d]) begin
                    chk($sformatf("dut%0d out_val", d), 32'(o_val[d]), 32'(last_val[d]));
                    chk($sformatf("dut%0d out_idx", d), 32'(o_idx[d]), 32'(last_idx[d]));
                end
            end
        end
    end

    initial begin
        fill(8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("dut%0d reset out_valid", d), 32'(o_vld[d]), 32'd0);
            chk($sformatf("dut%0d reset out_val", d), 32'(o_val[d]), 32'd0);
            chk($sformatf("dut%0d reset out_idx", d), 32'(o_idx[d]), 32'd0);
        end
        idle(2);

        // Basic vector, then idle long enough to see the held result.
        sc = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd0, 8'd2, 8'd8, 8'd4, 8'd5, 8'd6};
        send(1'b1, 1'b0);
        idle(7);

        // Ties.
        fill(8'h40);
        send(1'b1, 1'b0);
        fill(8'h00);
        sc[0] = 8'd5; sc[1] = 8'd9; sc[2] = 8'd9;
        send(1'b1, 1'b0);
        fill(8'h10);
        sc[4] = 8'hFF; sc[9] = 8'hFF;
        send(1'b1, 1'b0);
        idle(5);

        // Signedness.
        fill(8'h00);
        sc[0] = 8'h80; sc[1] = 8'h7F;
        send(1'b1, 1'b0);
        fill(8'h80);
        sc[7] = 8'hFF;
        send(1'b1, 1'b0);
        idle(5);

        // Pass-through element of the five-input tree wins.
        fill(8'h00);
        sc[0] = 8'd1; sc[1] = 8'd2; sc[2] = 8'd3; sc[3] = 8'd4; sc[4] = 8'd50;
        send(1'b1, 1'b0);
        idle(5);

        // Back-to-back stream, max 200 walking through the indices.
        for (int k = 0; k < 10; k++) begin
            fill(8'd10);
            sc[k] = 8'd200;
            send(1'b1, 1'b0);
        end
        idle(6);

        // Reset with two vectors in flight; in_valid during reset is ignored;
        // the vector right after reset must still come out.
        fill(8'd20); sc[2] = 8'd99;
        send(1'b1, 1'b0);
        fill(8'd30); sc[5] = 8'd77;
        send(1'b1, 1'b0);
        fill(8'd60); sc[1] = 8'd250;
        send(1'b1, 1'b1);
        fill(8'd11); sc[3] = 8'd33; sc[0] = 8'd12;
        send(1'b1, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("dut%0d post-reset out_valid", d), 32'(o_vld[d]), 32'd0);
            chk($sformatf("dut%0d post-reset out_val", d), 32'(o_val[d]), 32'd0);
            chk($sformatf("dut%0d post-reset out_idx", d), 32'(o_idx[d]), 32'd0);
        end
        idle(6);

        // Random traffic with frequent ties and sign-bit values.
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 10; i++)
                sc[i] = (k % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            send(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'b0);
        end
        idle(8);

        for (int d = 0; d < 4; d++)
            chk($sformatf("dut%0d drained", d), 32'(sb[d].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/argmax_tree.md
# argmax_tree

Parametrised, fully pipelined argmax over a vector of `NUM_INPUTS` scores, with optional signed comparison. It generalises the single registered two-input compare into a balanced tree of registered compare nodes. It accepts one new vector per cycle and returns the maximum value and its index after a fixed latency. It sits at the output of the neural-network classifier layer and drives the predicted-digit index to the display/control logic.

## Interface
- `RESOLUTION`, default 8: width of each score.
- `NUM_INPUTS`, default 10: number of scores per vector; must be ≥1.
- `SIGNED`, default 0: 0 = unsigned compare, 1 = two's-complement compare.
- `INDEX_SIZE`, default 4: index width; must be ≥ max(1, ceil(log2 NUM_INPUTS)).
- `clk` input 1: clock, all state on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_data` holds a vector this cycle.
- `in_data` input NUM_INPUTS*RESOLUTION: score i at bits [i*RESOLUTION +: RESOLUTION].
- `out_valid` output 1: `out_val`/`out_idx` hold a result this cycle.
- `out_val` output RESOLUTION: maximum score.
- `out_idx` output INDEX_SIZE: index of the maximum score.

## Operation
- Level 0 pairs score 2k (left) with 2k+1 (right).
- Each node registers the winner's value and index.
  - Left wins if left ≥ right, so ties go to the lower index.
  - Comparison is `$signed` when SIGNED=1, unsigned otherwise.
- Odd element at any level (non-power-of-two counts) passes through a plain register, keeping tree depth uniform.
- Each level carries a valid bit, advanced every cycle (no stall, no backpressure).
- Node data registers load only when their incoming valid bit is 1; otherwise they hold.
  - `out_val`/`out_idx` therefore hold the last result while `out_valid`=0.
- NUM_INPUTS=1: one pass-through register; `out_idx` is always 0.

## Timing
- Latency L = max(1, ceil(log2 NUM_INPUTS)) cycles from `in_valid` to `out_valid`.
  - NUM_INPUTS 10 → L=4.
  - NUM_INPUTS 5 → L=3.
- Throughput is one vector per cycle. Back-to-back vectors emerge on consecutive cycles, in order.
- Reset values: `out_valid`=0, `out_val`=0, `out_idx`=0, and all internal valid/data registers 0.
- Reset mid-operation discards every in-flight vector.
  - `out_valid` is 0 from the cycle after reset is sampled.
  - No pre-reset vector ever appears at the output.
- `in_valid` sampled while `reset`=1 is ignored.
- First vector after reset deassertion is accepted in the same cycle reset is low.
- No X-propagation: `in_data` content with `in_valid`=0 never affects outputs.

## Structure
- Shared package/header holds:
  - clog2 helper function.
  - Tree-depth constant computation: LATENCY = max(1, clog2(NUM_INPUTS)).
  - Per-level width function: ceil(n/2) per level.
- Sub-module `argmax_node` (params RESOLUTION, INDEX_SIZE, SIGNED):
  - Inputs: clk, reset, valid, two value/index pairs, and a `bypass` control for odd pass-through.
  - Outputs: registered winner value/index plus valid.
- Top level instantiates `argmax_node` in a generate loop per level, computing indices at level 0 as constants.

## Test plan
- Config NUM_INPUTS=10, RESOLUTION=8, SIGNED=0 unless stated.
- Basic: scores [3,7,1,9,0,2,8,4,5,6] (idx 0..9), one-cycle `in_valid` → exactly 4 cycles later `out_valid`=1 for 1 cycle, `out_val`=9, `out_idx`=3; outputs hold 9/3 afterwards.
- Ties: all scores 0x40 → `out_idx`=0. Scores [5,9,9,0,…] → `out_idx`=1. Max 0xFF at idx 4 and 9 → `out_idx`=4.
- Signedness:
  - SIGNED=0, scores idx0=0x80, idx1=0x7F, rest 0 → `out_idx`=0.
  - SIGNED=1, same scores → `out_idx`=1, `out_val`=0x7F.
  - SIGNED=1, all 0x80 except idx7=0xFF → `out_idx`=7.
- Streaming: 10 consecutive vectors, vector k has max 200 at idx k → `out_valid` high 10 consecutive cycles, `out_idx` sequence 0..9, no gaps or reordering.
- Reset mid-flight: issue 2 vectors, assert `reset` one cycle later for 1 cycle → `out_valid`=0 from the following cycle. Neither vector emerges. `out_val`/`out_idx`=0 until the next valid result.
- Odd sizes:
  - NUM_INPUTS=5, max at idx 4 (the pass-through element) → latency 3, `out_idx`=4.
  - NUM_INPUTS=1 → latency 1, `out_idx`=0, `out_val` equals the input.
